text2word: RTL and testbench

Streaming ASCII-number parser: successor to the single-digit ASCII-to-nibble decoder. Consumes one ASCII character per cycle over a valid/ready handshake and accumulates a multi-digit hexadecimal or decimal number into a WIDTH-bit word. Emits the word on a delimiter, with an error flag for illegal characters or overflow. Sits between the UART/text input path and command decoders.

---
 rtl/text2word.sv | 160 ++++++++++++++++
 tb/tb_text2word.sv | 341 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/text2word.sv
// Streaming ASCII hex/decimal number parser: one character per cycle in, one word per token out.
// Result is valid the cycle after the delimiter; input stalls (in_ready=0) while a result waits.
module text2word #(
    parameter int WIDTH     = 16,
    parameter bit RADIX_HEX = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       in_char,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_value,
    output logic             out_err,
    output logic [7:0]       out_len
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCUM,
        ST_ERR,
        ST_OUT
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [7:0]       len_q, len_d;
    logic [WIDTH-1:0] out_value_q, out_value_d;
    logic             out_err_q, out_err_d;
    logic [7:0]       out_len_q, out_len_d;

    logic             is_digit;
    logic             is_delim;
    logic [3:0]       digit_val;
    logic [WIDTH+3:0] acc_ext;
    logic [WIDTH+3:0] scaled;
    logic [WIDTH+3:0] next_val;
    logic             overflow;
    logic [7:0]       len_inc;
    logic             accept;

    // Character classification
    always_comb begin
        is_digit  = 1'b0;
        is_delim  = 1'b0;
        digit_val = 4'd0;
        if (in_char >= 8'h30 && in_char <= 8'h39) begin
            is_digit  = 1'b1;
            digit_val = in_char[3:0];
        end else if (RADIX_HEX &&
                     ((in_char >= 8'h41 && in_char <= 8'h46) ||
                      (in_char >= 8'h61 && in_char <= 8'h66))) begin
            // 'A'/'a' have low nibble 1, so +9 yields 10..15
            is_digit  = 1'b1;
            digit_val = in_char[3:0] + 4'd9;
        end
        is_delim = (in_char == 8'h20) || (in_char == 8'h0D) ||
                   (in_char == 8'h0A) || (in_char == 8'h2C);
    end

    // acc*R + d carried in four extra bits so overflow is visible in the top nibble
    always_comb begin
        acc_ext  = {4'b0000, acc_q};
        scaled   = RADIX_HEX ? (acc_ext << 4) : ((acc_ext << 3) + (acc_ext << 1));
        next_val = scaled + {{WIDTH{1'b0}}, digit_val};
        overflow = |next_val[WIDTH+3:WIDTH];
        len_inc  = (len_q == 8'hFF) ? 8'hFF : len_q + 8'd1;
    end

    assign in_ready  = (state_q != ST_OUT);
    assign out_valid = (state_q == ST_OUT);
    assign accept    = in_valid && in_ready;

    assign out_value = out_value_q;
    assign out_err   = out_err_q;
    assign out_len   = out_len_q;

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        len_d       = len_q;
        out_value_d = out_value_q;
        out_err_d   = out_err_q;
        out_len_d   = out_len_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (is_digit) begin
                        acc_d   = WIDTH'(digit_val);
                        len_d   = 8'd1;
                        state_d = ST_ACCUM;
                    end else if (!is_delim) begin
                        len_d   = 8'd0;
                        state_d = ST_ERR;
                    end
                end
            end
            ST_ACCUM: begin
                if (accept) begin
                    if (is_digit) begin
                        // The overflowing digit still counts toward the token length
                        len_d = len_inc;
                        if (overflow) begin
                            state_d = ST_ERR;
                        end else begin
                            acc_d = next_val[WIDTH-1:0];
                        end
                    end else if (is_delim) begin
                        out_value_d = acc_q;
                        out_err_d   = 1'b0;
                        out_len_d   = len_q;
                        state_d     = ST_OUT;
                    end else begin
                        state_d = ST_ERR;
                    end
                end
            end
            ST_ERR: begin
                if (accept) begin
                    if (is_digit) begin
                        len_d = len_inc;
                    end else if (is_delim) begin
                        out_value_d = '0;
                        out_err_d   = 1'b1;
                        out_len_d   = len_q;
                        state_d     = ST_OUT;
                    end
                end
            end
            ST_OUT: begin
                if (out_ready) begin
                    acc_d   = '0;
                    len_d   = 8'd0;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            acc_q       <= '0;
            len_q       <= 8'd0;
            out_value_q <= '0;
            out_err_q   <= 1'b0;
            out_len_q   <= 8'd0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            len_q       <= len_d;
            out_value_q <= out_value_d;
            out_err_q   <= out_err_d;
            out_len_q   <= out_len_d;
        end
    end

endmodule

// File: tb/tb_text2word.sv
// Bench for text2word: hex and decimal instances, table vectors, corner sequences, random streams.
module tb_text2word;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid_h, in_valid_d;
    logic         in_ready_h, in_ready_d;
    logic [7:0]   in_char;
    logic         out_ready;
    logic         out_valid_h, out_valid_d;
    logic [W-1:0] out_value_h, out_value_d;
    logic         out_err_h, out_err_d;
    logic [7:0]   out_len_h, out_len_d;

    always #5 clk = ~clk;

    text2word #(.WIDTH(W), .RADIX_HEX(1'b1)) dut_h (
        .clk(clk), .rst(rst),
        .in_valid(in_valid_h), .in_ready(in_ready_h), .in_char(in_char),
        .out_valid(out_valid_h), .out_ready(out_ready),
        .out_value(out_value_h), .out_err(out_err_h), .out_len(out_len_h)
    );

    text2word #(.WIDTH(W), .RADIX_HEX(1'b0)) dut_d (
        .clk(clk), .rst(rst),
        .in_valid(in_valid_d), .in_ready(in_ready_d), .in_char(in_char),
        .out_valid(out_valid_d), .out_ready(out_ready),
        .out_value(out_value_d), .out_err(out_err_d), .out_len(out_len_d)
    );

    typedef struct packed {
        logic [W-1:0] v;
        logic         e;
        logic [7:0]   l;
    } res_t;

    typedef struct packed {
        logic [95:0]  txt;
        logic         hex;
        logic [W-1:0] v;
        logic         e;
        logic [7:0]   l;
    } vec_t;

    res_t obs_h[$];
    res_t obs_d[$];
    res_t exp_q[$];
    byte  sent_q[$];
    int   checks = 0;
    int   errors = 0;
    bit   rnd_en = 1'b0;

    always @(negedge clk) begin
        if (!rst && out_valid_h && out_ready) obs_h.push_back('{v: out_value_h, e: out_err_h, l: out_len_h});
        if (!rst && out_valid_d && out_ready) obs_d.push_back('{v: out_value_d, e: out_err_d, l: out_len_d});
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rnd_en) out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_char(input bit hex, input byte c);
        int budget;
        bit rdy;
        budget  = 0;
        in_char = c;
        if (hex) in_valid_h = 1'b1;
        else     in_valid_d = 1'b1;
        forever begin
            @(negedge clk);
            rdy = hex ? in_ready_h : in_ready_d;
            @(posedge clk);
            #1;
            if (rdy) break;
            budget++;
            if (budget > 50) begin
                checks++;
                errors++;
                $display("FAIL accept_timeout: char 0x%0h not accepted within 50 cycles", c);
                break;
            end
        end
        in_valid_h = 1'b0;
        in_valid_d = 1'b0;
        sent_q.push_back(c);
    endtask

    task automatic send_str(input bit hex, input string s);
        for (int i = 0; i < s.len(); i++) send_char(hex, s[i]);
    endtask

    function automatic int digit_of(input byte c, input bit hex);
        if (c >= 8'h30 && c <= 8'h39) return int'(c) - 48;
        if (hex && c >= 8'h41 && c <= 8'h46) return int'(c) - 55;
        if (hex && c >= 8'h61 && c <= 8'h66) return int'(c) - 87;
        return -1;
    endfunction

    // Token-level reference: split on delimiters, evaluate each token with wide arithmetic
    task automatic run_model(input bit hex);
        longint val;
        bit     ovf, ill, in_tok;
        int     n, d, r;
        byte    c;
        res_t   res;
        r = hex ? 16 : 10;
        exp_q.delete();
        val = 0; ovf = 0; ill = 0; in_tok = 0; n = 0;
        foreach (sent_q[k]) begin
            c = sent_q[k];
            if (c == 8'h20 || c == 8'h0D || c == 8'h0A || c == 8'h2C) begin
                if (in_tok) begin
                    res.v = (ovf || ill) ? '0 : val[W-1:0];
                    res.e = ovf || ill;
                    res.l = 8'(n);
                    exp_q.push_back(res);
                end
                val = 0; ovf = 0; ill = 0; in_tok = 0; n = 0;
            end else begin
                in_tok = 1;
                d = digit_of(c, hex);
                if (d < 0) ill = 1;
                else begin
                    if (n < 255) n++;
                    if (!ovf) begin
                        val = val * r + d;
                        if (val >= (64'd1 << W)) ovf = 1;
                    end
                end
            end
        end
    endtask

    task automatic compare_q(input bit hex, input string tag);
        res_t got[$];
        int   m;
        run_model(hex);
        if (hex) got = obs_h;
        else     got = obs_d;
        check($sformatf("%s_count", tag), got.size(), exp_q.size());
        m = (got.size() < exp_q.size()) ? got.size() : exp_q.size();
        for (int i = 0; i < m; i++) begin
            check($sformatf("%s_value[%0d]", tag, i), got[i].v, exp_q[i].v);
            check($sformatf("%s_err[%0d]", tag, i), got[i].e, exp_q[i].e);
            check($sformatf("%s_len[%0d]", tag, i), got[i].l, exp_q[i].l);
        end
        obs_h.delete();
        obs_d.delete();
        sent_q.delete();
    endtask

    function automatic vec_t mk(input string s, input bit hex, input logic [W-1:0] v,
                                input bit e, input logic [7:0] l);
        vec_t t;
        t.txt = '0;
        for (int i = 0; i < s.len(); i++) t.txt = {t.txt[87:0], s[i]};
        t.hex = hex; t.v = v; t.e = e; t.l = l;
        return t;
    endfunction

    task automatic check_reset_outputs(input string tag);
        check({tag, "_valid_h"}, out_valid_h, 0);
        check({tag, "_value_h"}, out_value_h, 0);
        check({tag, "_err_h"},   out_err_h, 0);
        check({tag, "_len_h"},   out_len_h, 0);
        check({tag, "_ready_h"}, in_ready_h, 1);
        check({tag, "_valid_d"}, out_valid_d, 0);
        check({tag, "_ready_d"}, in_ready_d, 1);
    endtask

    function automatic byte rand_char();
        byte pool_delim[4] = '{8'h20, 8'h0D, 8'h0A, 8'h2C};
        byte pool_ill[5]   = '{8'h47, 8'h78, 8'h2E, 8'h2D, 8'h5A};
        int  r;
        r = $urandom_range(0, 99);
        if (r < 35) return byte'(8'h30 + $urandom_range(0, 9));
        if (r < 45) return 8'h30;
        if (r < 52) return byte'(8'h41 + $urandom_range(0, 5));
        if (r < 60) return byte'(8'h61 + $urandom_range(0, 5));
        if (r < 80) return pool_delim[$urandom_range(0, 3)];
        return pool_ill[$urandom_range(0, 4)];
    endfunction

    vec_t vecs[11];

    initial begin
        logic [7:0] c;
        vecs[0]  = mk("1A3f\r",      1'b1, 16'h1A3F, 1'b0, 8'd4);
        vecs[1]  = mk("0000FFFF ",   1'b1, 16'hFFFF, 1'b0, 8'd8);
        vecs[2]  = mk("10000 ",      1'b1, 16'h0000, 1'b1, 8'd5);
        vecs[3]  = mk("65535 ",      1'b0, 16'hFFFF, 1'b0, 8'd5);
        vecs[4]  = mk("65536 ",      1'b0, 16'h0000, 1'b1, 8'd5);
        vecs[5]  = mk("  12G4,",     1'b1, 16'h0000, 1'b1, 8'd3);
        vecs[6]  = mk("7\n",         1'b1, 16'h0007, 1'b0, 8'd1);
        vecs[7]  = mk("x\r",         1'b1, 16'h0000, 1'b1, 8'd0);
        vecs[8]  = mk("12a ",        1'b0, 16'h0000, 1'b1, 8'd2);
        vecs[9]  = mk("00099,",      1'b0, 16'd99,   1'b0, 8'd5);
        vecs[10] = mk(", fF ",       1'b1, 16'h00FF, 1'b0, 8'd2);

        rst = 1'b1; in_valid_h = 1'b0; in_valid_d = 1'b0; in_char = 8'h00; out_ready = 1'b1;
        idle(2);
        check_reset_outputs("reset");
        rst = 1'b0;
        idle(1);

        // Table vectors: exactly one result each
        foreach (vecs[i]) begin
            for (int b = 11; b >= 0; b--) begin
                c = vecs[i].txt[b*8 +: 8];
                if (c != 8'h00) send_char(vecs[i].hex, c);
            end
            idle(3);
            if (vecs[i].hex) begin
                check($sformatf("vec%0d_count", i), obs_h.size(), 1);
                if (obs_h.size() > 0) begin
                    check($sformatf("vec%0d_value", i), obs_h[0].v, vecs[i].v);
                    check($sformatf("vec%0d_err", i),   obs_h[0].e, vecs[i].e);
                    check($sformatf("vec%0d_len", i),   obs_h[0].l, vecs[i].l);
                end
            end else begin
                check($sformatf("vec%0d_count", i), obs_d.size(), 1);
                if (obs_d.size() > 0) begin
                    check($sformatf("vec%0d_value", i), obs_d[0].v, vecs[i].v);
                    check($sformatf("vec%0d_err", i),   obs_d[0].e, vecs[i].e);
                    check($sformatf("vec%0d_len", i),   obs_d[0].l, vecs[i].l);
                end
            end
            obs_h.delete(); obs_d.delete(); sent_q.delete();
        end

        // Latency: result visible right after the delimiter edge, gone one cycle later
        send_str(1'b1, "1A3f\r");
        check("lat_valid",    out_valid_h, 1);
        check("lat_value",    out_value_h, 16'h1A3F);
        check("lat_inready",  in_ready_h, 0);
        idle(1);
        check("lat_valid_off", out_valid_h, 0);
        check("lat_ready_on",  in_ready_h, 1);
        compare_q(1'b1, "lat");

        send_str(1'b0, "65535 65536 ");
        idle(3);
        compare_q(1'b0, "dec_pair");

        send_str(1'b1, "  12G4,7\n");
        idle(3);
        compare_q(1'b1, "hex_err_then_ok");

        // Backpressure hold
        out_ready = 1'b0;
        send_str(1'b1, "BEEF ");
        for (int k = 0; k < 5; k++) begin
            check($sformatf("bp_inready[%0d]", k), in_ready_h, 0);
            check($sformatf("bp_valid[%0d]", k),   out_valid_h, 1);
            check($sformatf("bp_value[%0d]", k),   out_value_h, 16'hBEEF);
            idle(1);
        end
        out_ready = 1'b1;
        idle(1);
        out_ready = 1'b0;
        check("bp_valid_off", out_valid_h, 0);
        check("bp_ready_on",  in_ready_h, 1);
        out_ready = 1'b1;
        compare_q(1'b1, "bp");

        // in_valid gaps
        send_str(1'b0, "9");
        idle(3);
        send_str(1'b0, "9");
        idle(1);
        send_str(1'b0, " ");
        idle(3);
        check("gap_value_direct", obs_d.size() > 0 ? obs_d[0].v : 16'hDEAD, 16'd99);
        compare_q(1'b0, "gap");

        // Reset mid-token discards it
        send_str(1'b1, "AB");
        rst = 1'b1;
        idle(1);
        check_reset_outputs("midrst_during");
        rst = 1'b0;
        idle(1);
        check_reset_outputs("midrst_after");
        sent_q.delete();
        send_str(1'b1, "C ");
        idle(3);
        compare_q(1'b1, "after_rst");

        // Length saturation at 255
        for (int k = 0; k < 300; k++) send_char(1'b1, 8'h30);
        send_char(1'b1, 8'h20);
        idle(3);
        compare_q(1'b1, "len_sat");

        // Random streams with random gaps and random out_ready
        for (int h = 1; h >= 0; h--) begin
            rnd_en = 1'b1;
            for (int k = 0; k < 400; k++) begin
                if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
                send_char(h[0], rand_char());
            end
            send_char(h[0], 8'h20);
            rnd_en = 1'b0;
            idle(1);
            out_ready = 1'b1;
            idle(4);
            compare_q(h[0], h ? "rand_hex" : "rand_dec");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
